// File: rtl/battleship_btn_debounce.sv
// N-channel button/switch debouncer: 2-flop synchroniser, shared tick prescaler,
// per-channel confirm FSM with level + press/release pulses. Optional auto-repeat via BTN_AUTOREPEAT_EN.
module battleship_btn_debounce #(
  parameter int CHANNELS     = 5,
  parameter int TICK_DIV     = 500000,
  parameter int STABLE_TICKS = 4,
  parameter int REPEAT_DELAY = 100,
  parameter int REPEAT_RATE  = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] btn_in,
  output logic [CHANNELS-1:0] btn_level,
  output logic [CHANNELS-1:0] btn_press,
  output logic [CHANNELS-1:0] btn_release,
  output logic                tick
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CNT_W = $clog2(STABLE_TICKS + 1);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_TICKS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

`ifdef BTN_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] REP_ONE   = REP_W'(1);
  localparam logic [REP_W-1:0] REP_DELAY = REP_W'(REPEAT_DELAY);
  localparam logic [REP_W-1:0] REP_RATE  = REP_W'(REPEAT_RATE);
`endif

  if (CHANNELS < 1 || TICK_DIV < 1 || STABLE_TICKS < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
    $error("battleship_btn_debounce: all parameters must be >= 1");
  end

  typedef enum logic [1:0] {
    ST_LOW          = 2'd0,
    ST_CONFIRM_HIGH = 2'd1,
    ST_HIGH         = 2'd2,
    ST_CONFIRM_LOW  = 2'd3
  } state_e;

  logic [CHANNELS-1:0] sync0_q;
  logic [CHANNELS-1:0] sync_q;
  logic [DIV_W-1:0]    div_q;
  logic                tick_q;
  state_e              state_q [CHANNELS];
  logic [CNT_W-1:0]    cnt_q   [CHANNELS];
  logic [CHANNELS-1:0] level_q;
  logic [CHANNELS-1:0] press_q;
  logic [CHANNELS-1:0] release_q;
`ifdef BTN_AUTOREPEAT_EN
  logic [REP_W-1:0]    rep_q   [CHANNELS];
  logic [CHANNELS-1:0] armed_q;
`endif

  // Two-flop synchroniser for the asynchronous raw inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0_q <= '0;
      sync_q  <= '0;
    end else begin
      sync0_q <= btn_in;
      sync_q  <= sync0_q;
    end
  end

  // Shared prescaler; tick is registered so it lands the cycle after the wrap value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      if (div_q == DIV_MAX) begin
        div_q <= '0;
      end else begin
        div_q <= div_q + DIV_ONE;
      end
      tick_q <= (div_q == DIV_MAX);
    end
  end

  // Per-channel confirmation FSM with registered level and one-cycle pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
`ifdef BTN_AUTOREPEAT_EN
      armed_q   <= '0;
`endif
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= ST_LOW;
        cnt_q[i]   <= '0;
`ifdef BTN_AUTOREPEAT_EN
        rep_q[i]   <= '0;
`endif
      end
    end else begin
      press_q   <= '0;
      release_q <= '0;
      if (tick_q) begin
        for (int i = 0; i < CHANNELS; i++) begin
`ifdef BTN_AUTOREPEAT_EN
          // Any tick spent outside HIGH restarts the repeat delay
          if (state_q[i] != ST_HIGH) begin
            rep_q[i]   <= '0;
            armed_q[i] <= 1'b0;
          end
`endif
          case (state_q[i])
            ST_LOW: begin
              if (sync_q[i]) begin
                if (CNT_MAX == CNT_ONE) begin
                  state_q[i] <= ST_HIGH;
                  level_q[i] <= 1'b1;
                  press_q[i] <= 1'b1;
                  cnt_q[i]   <= '0;
                end else begin
                  state_q[i] <= ST_CONFIRM_HIGH;
                  cnt_q[i]   <= CNT_ONE;
                end
              end
            end
            ST_CONFIRM_HIGH: begin
              if (!sync_q[i]) begin
                state_q[i] <= ST_LOW;
                cnt_q[i]   <= '0;
              end else if ((cnt_q[i] + CNT_ONE) == CNT_MAX) begin
                state_q[i] <= ST_HIGH;
                level_q[i] <= 1'b1;
                press_q[i] <= 1'b1;
                cnt_q[i]   <= '0;
              end else begin
                cnt_q[i] <= cnt_q[i] + CNT_ONE;
              end
            end
            ST_HIGH: begin
              if (!sync_q[i]) begin
`ifdef BTN_AUTOREPEAT_EN
                rep_q[i]   <= '0;
                armed_q[i] <= 1'b0;
`endif
                if (CNT_MAX == CNT_ONE) begin
                  state_q[i]   <= ST_LOW;
                  level_q[i]   <= 1'b0;
                  release_q[i] <= 1'b1;
                  cnt_q[i]     <= '0;
                end else begin
                  state_q[i] <= ST_CONFIRM_LOW;
                  cnt_q[i]   <= CNT_ONE;
                end
              end
`ifdef BTN_AUTOREPEAT_EN
              else if ((rep_q[i] + REP_ONE) == (armed_q[i] ? REP_RATE : REP_DELAY)) begin
                press_q[i] <= 1'b1;
                rep_q[i]   <= '0;
                armed_q[i] <= 1'b1;
              end else begin
                rep_q[i] <= rep_q[i] + REP_ONE;
              end
`endif
            end
            ST_CONFIRM_LOW: begin
              if (sync_q[i]) begin
                state_q[i] <= ST_HIGH;
                cnt_q[i]   <= '0;
              end else if ((cnt_q[i] + CNT_ONE) == CNT_MAX) begin
                state_q[i]   <= ST_LOW;
                level_q[i]   <= 1'b0;
                release_q[i] <= 1'b1;
                cnt_q[i]     <= '0;
              end else begin
                cnt_q[i] <= cnt_q[i] + CNT_ONE;
              end
            end
            default: begin
              state_q[i] <= ST_LOW;
              level_q[i] <= 1'b0;
              cnt_q[i]   <= '0;
            end
          endcase
        end
      end
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign tick        = tick_q;

endmodule

// File: tb/tb_battleship_btn_debounce.sv
// Scoreboard bench: a tick/agreement-count reference model queues the expected outputs per cycle,
// a negedge monitor pops and compares; directed scenarios add latency/coincidence checks.
module tb_battleship_btn_debounce;

  localparam int CH = 2;
  localparam int TD = 4;
  localparam int ST = 3;
  localparam int RD = 5;
  localparam int RR = 2;

  typedef struct packed {
    logic [CH-1:0] level;
    logic [CH-1:0] press;
    logic [CH-1:0] rel;
    logic          tick;
  } snap_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CH-1:0] btn_in;
  logic [CH-1:0] btn_level;
  logic [CH-1:0] btn_press;
  logic [CH-1:0] btn_release;
  logic          tick;

  int n_pass  = 0;
  int n_total = 0;

  battleship_btn_debounce #(
    .CHANNELS(CH), .TICK_DIV(TD), .STABLE_TICKS(ST),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in),
    .btn_level(btn_level), .btn_press(btn_press),
    .btn_release(btn_release), .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
  endtask

  // Reference model: each channel flips after ST consecutive ticks where the
  // synchronised input disagrees with the current level.
  snap_t         exp_q[$];
  snap_t         m_e;
  bit            model_live;
  int            k;
  logic [CH-1:0] s1, s2, m_level;
  int            dis  [CH];
  int            hold [CH];
  bit            tick_prev;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k = 0; s1 = '0; s2 = '0; m_level = '0; model_live = 1'b0;
      exp_q.delete();
      for (int c = 0; c < CH; c++) begin dis[c] = 0; hold[c] = 0; end
    end else begin
      k++;
      tick_prev = (k >= 2) && (((k - 1) % TD) == 0);
      m_e.press = '0;
      m_e.rel   = '0;
      if (tick_prev) begin
        for (int c = 0; c < CH; c++) begin
          if (s2[c] != m_level[c]) begin
            hold[c] = 0;
            dis[c]++;
            if (dis[c] == ST) begin
              m_level[c] = ~m_level[c];
              dis[c] = 0;
              if (m_level[c]) m_e.press[c] = 1'b1;
              else            m_e.rel[c]   = 1'b1;
            end
          end else begin
            if (m_level[c] && dis[c] == 0) begin
              hold[c]++;
`ifdef BTN_AUTOREPEAT_EN
              if (hold[c] == RD || (hold[c] > RD && ((hold[c] - RD) % RR) == 0))
                m_e.press[c] = 1'b1;
`endif
            end
            dis[c] = 0;
          end
        end
      end
      m_e.level = m_level;
      m_e.tick  = ((k % TD) == 0);
      s2 = s1;
      s1 = btn_in;
      exp_q.push_back(m_e);
      model_live = 1'b1;
    end
  end

  // Monitor: compare DUT outputs against the queued expectation each cycle
  snap_t mon_a, mon_e;
  always @(negedge clk) begin
    mon_a = {btn_level, btn_press, btn_release, tick};
    if (rst_n && model_live) begin
      check("scoreboard_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("cycle_outputs", {25'd0, mon_a}, {25'd0, mon_e});
      end
    end else begin
      check("idle_outputs_zero", {25'd0, mon_a}, 32'd0);
    end
  end

  task automatic wait_pulse(input logic is_rel, input logic [CH-1:0] mask, input int budget,
                            output int cyc, output logic [CH-1:0] seen);
    cyc  = -1;
    seen = '0;
    for (int n = 1; n <= budget; n++) begin
      @(negedge clk);
      if (((is_rel ? btn_release : btn_press) & mask) != '0) begin
        cyc  = n;
        seen = is_rel ? btn_release : btn_press;
        break;
      end
    end
  endtask

  initial begin
    int            cyc;
    int            nt;
    int            presses;
    logic [CH-1:0] seen;
    logic [31:0]   rnd;

    rst_n = 1'b0; btn_in = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {25'd0, btn_level, btn_press, btn_release, tick}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Clean press and release on ch0
    btn_in[0] = 1'b1;
    wait_pulse(1'b0, 2'b11, 20, cyc, seen);
    check("clean_press_within_15", 32'(cyc >= 1 && cyc <= 15), 32'd1);
    check("clean_press_channel", seen, 2'b01);
    check("clean_level", btn_level, 2'b01);
    repeat (4) @(negedge clk);
    btn_in[0] = 1'b0;
    wait_pulse(1'b1, 2'b11, 20, cyc, seen);
    check("clean_release_channel", seen, 2'b01);
    repeat (5) @(negedge clk);

    // Bounce on ch0, then settle low
    for (int n = 0; n < 20; n++) begin
      btn_in[0] = ~btn_in[0];
      repeat (2) @(negedge clk);
    end
    btn_in[0] = 1'b0;
    repeat (40) @(negedge clk);
    check("bounce_settled_low", btn_level, 2'b00);

    // Single tick-period glitch on ch1
    btn_in[1] = 1'b1;
    repeat (TD) @(negedge clk);
    btn_in[1] = 1'b0;
    wait_pulse(1'b0, 2'b10, 30, cyc, seen);
    check("glitch_no_press", cyc, -1);
    check("glitch_level_low", btn_level, 2'b00);

    // Simultaneous press and release on both channels
    btn_in = 2'b11;
    wait_pulse(1'b0, 2'b11, 20, cyc, seen);
    check("simul_press_both", seen, 2'b11);
    repeat (6) @(negedge clk);
    btn_in = 2'b00;
    wait_pulse(1'b1, 2'b11, 20, cyc, seen);
    check("simul_release_both", seen, 2'b11);
    check("simul_release_within_15", 32'(cyc >= 1 && cyc <= 15), 32'd1);
    check("simul_level_low", btn_level, 2'b00);
    repeat (10) @(negedge clk);

    // Reset after two confirming ticks, input held through reset
    btn_in[0] = 1'b1;
    repeat (2) @(negedge clk);
    nt = 0;
    for (int n = 0; n < 20; n++) begin
      if (tick) nt++;
      if (nt == 2) break;
      @(negedge clk);
    end
    check("two_confirm_ticks_seen", nt, 2);
    check("pre_reset_level_low", btn_level, 2'b00);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("reset_async_zero", {25'd0, btn_level, btn_press, btn_release, tick}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nt = 0; cyc = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (btn_press[0]) begin cyc = n; break; end
      if (tick) nt++;
    end
    check("retrigger_press_seen", 32'(cyc > 0), 32'd1);
    check("retrigger_ticks", nt, 3);
`ifdef BTN_AUTOREPEAT_EN
    presses = 1;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (btn_press[0]) presses++;
    end
    check("autorepeat_pulses", 32'(presses >= 3), 32'd1);
`else
    presses = 0;
`endif
    btn_in[0] = 1'b0;
    wait_pulse(1'b1, 2'b01, 20, cyc, seen);
    check("retrigger_release", seen, 2'b01);

    // Randomised hold lengths on both channels
    for (int seg = 0; seg < 200; seg++) begin
      rnd = $urandom;
      btn_in = rnd[CH-1:0];
      repeat ($urandom_range(1, (seg % 4 == 0) ? 40 : 6)) @(negedge clk);
    end
    btn_in = '0;
    repeat (40) @(negedge clk);
    check("final_level_low", btn_level, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
